// File: rtl/katapayadi_pkg.sv
// Shared Katapayadi definitions: decoder FSM states, decimal weights and the
// consonant glyph tables used by both the encoder and the decoder.
package katapayadi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_EMIT,
    ST_FINISH
  } kp_state_t;

  localparam logic [7:0] GLYPH_INVALID = 8'h3F;
  localparam logic [3:0] DIGIT_NONE    = 4'hF;

  // Index 0 is the rightmost entry; digit 9 has no consonant and maps to '?'.
  localparam logic [9:0][7:0] GLYPH_PRI = {
    8'h3F, 8'h6A, 8'h73, 8'h63, 8'h6D, 8'h76, 8'h67, 8'h72, 8'h6B, 8'h6E
  };
  localparam logic [9:0][7:0] GLYPH_ALT = {
    8'h3F, 8'h68, 8'h73, 8'h63, 8'h6D, 8'h76, 8'h64, 8'h72, 8'h74, 8'h6E
  };

  function automatic logic [63:0] pow10(input logic [4:0] k);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < 19; i++) begin
      if (5'(i) < k) r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/katapayadi_glyph.sv
// Combinational decimal digit to Katapayadi consonant lookup with a flag for
// digit 9, which has no consonant of its own.
module katapayadi_glyph
  import katapayadi_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       alt,
  output logic [7:0] glyph,
  output logic       is_nine
);

  always_comb begin
    glyph   = GLYPH_INVALID;
    is_nine = (digit == 4'd9);
    if (digit != DIGIT_NONE && digit <= 4'd9) begin
      glyph = alt ? GLYPH_ALT[digit] : GLYPH_PRI[digit];
    end
  end

endmodule

// File: rtl/katapayadi_decode.sv
// Binary number to Katapayadi consonant stream, most-significant digit first,
// found by repeated subtraction of powers of ten, one compare per cycle.
module katapayadi_decode
  import katapayadi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_number,
  input  logic                  in_alt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_char,
  output logic [3:0]            out_digit,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            digit_count,
  output logic                  err_nine
);

  localparam int         RW    = DATA_WIDTH + 4;
  localparam logic [3:0] K_TOP = 4'(MAX_DIGITS - 1);

  kp_state_t       state_q, state_d;
  logic [RW-1:0]   rem_q;
  logic [3:0]      k_q, cnt_q, dcount_q;
  logic            started_q, alt_q, nine_seen_q, err_nine_q;
  logic [63:0]     pow_full;
  logic [RW-1:0]   pow_k;
  logic            ge, skip, accept, out_hs;
  logic [7:0]      glyph;
  logic            is_nine;

  assign pow_full = pow10({1'b0, k_q});
  assign pow_k    = pow_full[RW-1:0];
  assign ge       = (rem_q >= pow_k);
  // A zero digit before any digit has been emitted is a leading zero, except the units digit.
  assign skip     = !ge && (cnt_q == 4'd0) && !started_q && (k_q != 4'd0);
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  katapayadi_glyph u_glyph (
    .digit   (cnt_q),
    .alt     (alt_q),
    .glyph   (glyph),
    .is_nine (is_nine)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_CONVERT;
      ST_CONVERT: if (!ge && !skip) state_d = ST_EMIT;
      ST_EMIT:    if (out_hs) state_d = (k_q == 4'd0) ? ST_FINISH : ST_CONVERT;
      ST_FINISH:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Control path: digit position, running digit, and per-number status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q         <= 4'd0;
      cnt_q       <= 4'd0;
      started_q   <= 1'b0;
      alt_q       <= 1'b0;
      dcount_q    <= 4'd0;
      nine_seen_q <= 1'b0;
      err_nine_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          alt_q       <= in_alt;
          k_q         <= K_TOP;
          cnt_q       <= 4'd0;
          started_q   <= 1'b0;
          dcount_q    <= 4'd0;
          nine_seen_q <= 1'b0;
          err_nine_q  <= 1'b0;
        end
        ST_CONVERT: begin
          if (ge)        cnt_q <= cnt_q + 4'd1;
          else if (skip) k_q   <= k_q - 4'd1;
        end
        ST_EMIT: if (out_hs) begin
          started_q   <= 1'b1;
          dcount_q    <= dcount_q + 4'd1;
          nine_seen_q <= nine_seen_q | is_nine;
          if (k_q == 4'd0) begin
            err_nine_q <= nine_seen_q | is_nine;
          end else begin
            k_q   <= k_q - 4'd1;
            cnt_q <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath: remainder only matters between accept and finish, so it carries no reset
  always_ff @(posedge clk) begin
    if (accept)                          rem_q <= {4'b0, in_number};
    else if (state_q == ST_CONVERT && ge) rem_q <= rem_q - pow_k;
  end

  always_comb begin
    in_ready    = (state_q == ST_IDLE);
    out_valid   = (state_q == ST_EMIT);
    out_char    = out_valid ? glyph : 8'h00;
    out_digit   = out_valid ? cnt_q : 4'd0;
    out_last    = out_valid && (k_q == 4'd0);
    busy        = (state_q == ST_CONVERT) || (state_q == ST_EMIT);
    done        = (state_q == ST_FINISH);
    digit_count = dcount_q;
    err_nine    = err_nine_q;
  end

endmodule

// File: tb/tb_katapayadi_decode.sv
// Bench for katapayadi_decode: directed table, stall/reset sequences and
// random numbers checked against a digit-by-digit decimal model.
module tb_katapayadi_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_alt;
  logic [31:0] in_number;
  logic        out_valid, out_ready, out_last, busy, done, err_nine;
  logic [7:0]  out_char;
  logic [3:0]  out_digit, digit_count;

  katapayadi_decode #(.DATA_WIDTH(32), .MAX_DIGITS(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_number(in_number), .in_alt(in_alt), .out_valid(out_valid),
    .out_ready(out_ready), .out_char(out_char), .out_digit(out_digit),
    .out_last(out_last), .busy(busy), .done(done),
    .digit_count(digit_count), .err_nine(err_nine)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  byte  got_c[$];
  int   got_d[$];
  int   got_last_pos, last_cnt;
  logic got_nine, fin, hold_bad, ready_leak;
  logic [3:0] got_cnt;
  byte  exp_c[$];
  int   exp_d[$];
  logic exp_nine;

  typedef struct {
    logic [31:0] num;
    logic        alt;
    logic [79:0] exp;
    int          len;
    logic        nine;
  } tv_t;
  tv_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Decimal digits by plain division, mapped through the glyph lists as strings.
  task automatic build_model(input longint unsigned n, input logic a);
    string pri, alts;
    int d;
    pri  = "nkrgvmcsj?";
    alts = "ntrdvmcsh?";
    exp_d.delete();
    exp_c.delete();
    exp_nine = 1'b0;
    do begin
      exp_d.push_front(int'(n % 10));
      n = n / 10;
    end while (n != 0);
    foreach (exp_d[i]) begin
      d = exp_d[i];
      exp_c.push_back(a ? alts[d] : pri[d]);
      if (d == 9) exp_nine = 1'b1;
    end
  endtask

  task automatic run(input logic [31:0] num, input logic a, input int stall_at, input int stall_len);
    int   cyc, stall;
    logic stalled_once, holding;
    logic [7:0] held_c;
    logic held_last;
    got_c.delete(); got_d.delete();
    got_last_pos = -1; last_cnt = 0; fin = 0; hold_bad = 0; ready_leak = 0;
    stall = 0; stalled_once = 0; holding = 0; held_c = 8'h00; held_last = 1'b0;
    @(negedge clk);
    in_number = num; in_alt = a; in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("accept_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_number = $urandom; in_alt = ~a;
    for (cyc = 0; cyc < 600 && !fin; cyc++) begin
      @(negedge clk);
      if (done) begin
        fin = 1'b1;
        got_cnt = digit_count;
        got_nine = err_nine;
      end else begin
        if (in_ready) ready_leak = 1'b1;
        if (stall_len > 0 && !stalled_once && out_valid && got_c.size() == stall_at) begin
          stall = stall_len;
          stalled_once = 1'b1;
        end
        if (stall > 0) begin
          out_ready = 1'b0;
          stall--;
          if (out_valid) begin
            if (!holding) begin
              holding = 1'b1; held_c = out_char; held_last = out_last;
            end else if (out_char !== held_c || out_last !== held_last) hold_bad = 1'b1;
          end else if (holding) hold_bad = 1'b1;
        end else begin
          out_ready = 1'b1;
          if (holding && (!out_valid || out_char !== held_c || out_last !== held_last))
            hold_bad = 1'b1;
          holding = 1'b0;
          if (out_valid) begin
            got_c.push_back(out_char);
            got_d.push_back(int'(out_digit));
            if (out_last) begin
              got_last_pos = got_c.size() - 1;
              last_cnt++;
            end
          end
        end
      end
    end
    check("done_seen", {63'd0, fin}, 64'd1);
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("ready_after_done", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic compare_result();
    check("char_count", got_c.size(), exp_c.size());
    for (int i = 0; i < exp_c.size() && i < got_c.size(); i++) begin
      check("char", {56'd0, got_c[i]}, {56'd0, exp_c[i]});
      check("digit", got_d[i], exp_d[i]);
    end
    check("last_position", got_last_pos, exp_c.size() - 1);
    check("last_once", last_cnt, 1);
    check("digit_count", {60'd0, got_cnt}, exp_c.size());
    check("err_nine", {63'd0, got_nine}, {63'd0, exp_nine});
    check("held_while_stalled", {63'd0, hold_bad}, 64'd0);
    check("in_ready_low_busy", {63'd0, ready_leak}, 64'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst out_valid", {63'd0, out_valid}, 64'd0);
    check("rst out_char", {56'd0, out_char}, 64'd0);
    check("rst out_digit", {60'd0, out_digit}, 64'd0);
    check("rst out_last", {63'd0, out_last}, 64'd0);
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst done", {63'd0, done}, 64'd0);
    check("rst digit_count", {60'd0, digit_count}, 64'd0);
    check("rst err_nine", {63'd0, err_nine}, 64'd0);
  endtask

  initial begin
    int hs, cyc;
    rst = 1'b1; in_valid = 1'b0; in_number = 32'd0; in_alt = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

    tbl[0] = '{32'd31415, 1'b0, 80'("gkvkm"), 5, 1'b0};
    tbl[1] = '{32'd0,     1'b0, 80'("n"),     1, 1'b0};
    tbl[2] = '{32'd318,   1'b1, 80'("dth"),   3, 1'b0};
    tbl[3] = '{32'd318,   1'b0, 80'("gkj"),   3, 1'b0};
    tbl[4] = '{32'd1900,  1'b0, 80'("k?nn"),  4, 1'b1};
    tbl[5] = '{32'd25,    1'b0, 80'("rm"),    2, 1'b0};
    for (int t = 0; t < 6; t++) begin
      build_model(64'(tbl[t].num), tbl[t].alt);
      exp_c.delete();
      for (int i = 0; i < tbl[t].len; i++) exp_c.push_back(tbl[t].exp[8*(tbl[t].len-1-i) +: 8]);
      exp_nine = tbl[t].nine;
      run(tbl[t].num, tbl[t].alt, -1, 0);
      compare_result();
    end

    // Maximum value with the sink stalled once three chars have gone out.
    build_model(64'd4294967295, 1'b0);
    run(32'hFFFF_FFFF, 1'b0, 3, 5);
    compare_result();

    // Reset while the second char of 31415 is being offered.
    @(negedge clk);
    in_number = 32'd31415; in_alt = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    hs = 0;
    for (cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (out_valid && hs == 1) break;
      if (out_valid) hs++;
    end
    check("second_char_offered", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset_outputs();
    check("rst in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_replay_after_reset", {63'd0, out_valid}, 64'd0);
    end
    build_model(64'd7, 1'b0);
    run(32'd7, 1'b0, -1, 0);
    compare_result();

    for (int r = 0; r < 25; r++) begin
      logic [31:0] n;
      logic a;
      n = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 99)) : $urandom;
      a = 1'($urandom_range(0, 1));
      build_model(64'(n), a);
      run(n, a, $urandom_range(0, 3), $urandom_range(0, 4));
      compare_result();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
